alu_op_scheduler: RTL and testbench

ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_iter_unit.sv | 97 +++++++++
 rtl/alu_op_scheduler.sv | 170 +++++++++++++++++
 tb/tb_alu_op_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operation scheduler.
//   alu_op_e     : opcode encoding (ADD/SUB/MUL/DIV)
//   alu_state_e  : scheduler FSM states
//   OPW_DEFAULT  : default operand width
package alu_pkg;

    localparam int unsigned OPW_DEFAULT = 3;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative MUL (shift-add) / DIV (restoring) engine, one step per enabled cycle.
// Ports:
//   clk, rst        : clock, async active-high reset
//   ena             : global enable, freezes all state when low
//   start           : load operands and begin an OPW-step operation
//   op, a, b        : opcode (MUL/DIV) and unsigned operands, sampled on start
//   done            : high during the final step; result/dz are valid then
//   result          : product, zero-extended quotient, or all ones on divide-by-zero
//   dz              : divide-by-zero flag
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int unsigned OPW = OPW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  alu_op_e          op,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic             done,
    output logic [2*OPW-1:0] result,
    output logic             dz
);
    localparam int unsigned RW = 2 * OPW;
    localparam int unsigned CW = $clog2(OPW + 1);

    logic           run_q;
    logic [CW-1:0]  cnt_q;
    logic           is_div_q;
    logic           dz_q;
    logic [RW-1:0]  prod_q;
    logic [RW-1:0]  mcand_q;
    logic [OPW-1:0] mplier_q;
    logic [OPW-1:0] divb_q;
    logic [OPW-1:0] rem_q;
    logic [OPW-1:0] quo_q;

    logic [RW-1:0]  prod_n;
    logic [OPW:0]   rem_sh;
    logic           ge;
    logic [OPW-1:0] rem_n;
    logic [OPW-1:0] quo_n;

    // One iteration step; result is taken from the step values on the last cycle
    always_comb begin
        prod_n = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
        rem_sh = {rem_q, quo_q[OPW-1]};
        ge     = (rem_sh >= {1'b0, divb_q});
        rem_n  = ge ? OPW'(rem_sh - {1'b0, divb_q}) : OPW'(rem_sh);
        quo_n  = {quo_q[OPW-2:0], ge};
        done   = run_q && (cnt_q == CW'(OPW - 1));
        result = dz_q ? {RW{1'b1}} : (is_div_q ? RW'(quo_n) : prod_n);
        dz     = dz_q;
    end

    // Operand load and iteration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            divb_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
        end else if (ena) begin
            if (start) begin
                run_q    <= 1'b1;
                cnt_q    <= '0;
                is_div_q <= (op == OP_DIV);
                dz_q     <= (op == OP_DIV) && (b == '0);
                prod_q   <= '0;
                mcand_q  <= RW'(a);
                mplier_q <= b;
                divb_q   <= b;
                rem_q    <= '0;
                quo_q    <= a;
            end else if (run_q) begin
                cnt_q    <= cnt_q + CW'(1);
                prod_q   <= prod_n;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                rem_q    <= rem_n;
                quo_q    <= quo_n;
                if (done) begin
                    run_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Two-requester ALU scheduler: round-robin grant, ADD/SUB in one cycle,
// MUL/DIV through the iterative unit, registered response with handshake.
// Ports:
//   clk, rst                    : clock, async active-high reset
//   ena                         : global enable, freezes all state when low
//   reqN_valid/ready            : request handshake for requester N (ready is a grant decode)
//   reqN_op, reqN_a, reqN_b     : opcode and unsigned operands
//   rsp_valid/ready             : response handshake
//   rsp_data, rsp_id, rsp_dz    : result, owning requester, divide-by-zero flag
//   busy                        : high whenever the FSM is not idle
module alu_op_scheduler
    import alu_pkg::*;
#(
    parameter int unsigned OPW = OPW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [OPW-1:0]   req0_a,
    input  logic [OPW-1:0]   req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [OPW-1:0]   req1_a,
    input  logic [OPW-1:0]   req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2*OPW-1:0] rsp_data,
    output logic             rsp_id,
    output logic             rsp_dz,
    output logic             busy
);
    localparam int unsigned RW = 2 * OPW;

    alu_state_e     state_q, state_d;
    alu_op_e        op_q, op_d;
    logic [OPW-1:0] a_q, a_d;
    logic [OPW-1:0] b_q, b_d;
    logic           id_q, id_d;
    logic           last_q, last_d;
    logic           rsp_valid_d;
    logic [RW-1:0]  rsp_data_d;
    logic           rsp_id_d;
    logic           rsp_dz_d;
    logic           busy_d;

    logic           grant1;
    logic           can_accept;
    logic           accept;
    alu_op_e        sel_op;
    logic [OPW-1:0] sel_a;
    logic [OPW-1:0] sel_b;
    logic           iter_start;
    logic           iter_done;
    logic           iter_dz;
    logic [RW-1:0]  iter_result;

    // Round-robin grant; ready is gated by rst so it drops immediately on reset
    always_comb begin
        grant1     = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        can_accept = (state_q == ST_IDLE) && ena && !rst;
        req0_ready = can_accept && req0_valid && !grant1;
        req1_ready = can_accept && req1_valid && grant1;
        accept     = req0_ready || req1_ready;
        sel_op     = grant1 ? alu_op_e'(req1_op) : alu_op_e'(req0_op);
        sel_a      = grant1 ? req1_a : req0_a;
        sel_b      = grant1 ? req1_b : req0_b;
        iter_start = accept && ((sel_op == OP_MUL) || (sel_op == OP_DIV));
    end

    alu_iter_unit #(
        .OPW(OPW)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .start  (iter_start),
        .op     (sel_op),
        .a      (sel_a),
        .b      (sel_b),
        .done   (iter_done),
        .result (iter_result),
        .dz     (iter_dz)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        last_d      = last_q;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_id_d    = rsp_id;
        rsp_dz_d    = rsp_dz;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = sel_op;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    id_d    = grant1;
                    last_d  = grant1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
                    rsp_data_d  = (op_q == OP_ADD) ? (RW'(a_q) + RW'(b_q))
                                                   : (RW'(a_q) - RW'(b_q));
                    rsp_dz_d    = 1'b0;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (iter_done) begin
                    rsp_data_d  = iter_result;
                    rsp_dz_d    = iter_dz;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; last_q resets to 1 so req0 wins the first contest
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            last_q    <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            rsp_dz    <= 1'b0;
            busy      <= 1'b0;
        end else if (ena) begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            id_q      <= id_d;
            last_q    <= last_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_id    <= rsp_id_d;
            rsp_dz    <= rsp_dz_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Self-checking bench for alu_op_scheduler: directed scenarios plus random
// single-requester transactions checked against an arithmetic reference model.
module tb_alu_op_scheduler;

    localparam int OPW  = 3;
    localparam int RW   = 2 * OPW;
    localparam int MASK = (1 << RW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           ena;
    logic           req0_valid, req1_valid;
    logic           req0_ready, req1_ready;
    logic [1:0]     req0_op, req1_op;
    logic [OPW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic           rsp_valid, rsp_ready;
    logic [RW-1:0]  rsp_data;
    logic           rsp_id, rsp_dz, busy;

    int errors = 0;
    int checks = 0;
    int last_grant = 1;

    alu_op_scheduler #(.OPW(OPW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_dz     (rsp_dz),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference arithmetic straight from the opcode definitions
    function automatic int exp_res(input int op, input int a, input int b);
        case (op)
            0:       return (a + b) & MASK;
            1:       return (a - b) & MASK;
            2:       return (a * b) & MASK;
            default: return (b == 0) ? MASK : (a / b);
        endcase
    endfunction

    task automatic drive_req(input int r, input int op, input int a, input int b);
        if (r == 0) begin
            req0_valid = 1'b1;
            req0_op    = 2'(op);
            req0_a     = OPW'(a);
            req0_b     = OPW'(b);
        end else begin
            req1_valid = 1'b1;
            req1_op    = 2'(op);
            req1_a     = OPW'(a);
            req1_b     = OPW'(b);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One uncontested transaction from requester r with optional response stall
    task automatic run_txn(input int r, input int op, input int a, input int b,
                           input int hold, input int eager);
        int n;
        int lat_exp;
        int d_exp;
        lat_exp = (op < 2) ? 1 : OPW;
        d_exp   = exp_res(op, a, b);
        drive_req(r, op, a, b);
        #1;
        chk("grant_own",   (r == 1) ? int'(req1_ready) : int'(req0_ready), 1);
        chk("grant_other", (r == 1) ? int'(req0_ready) : int'(req1_ready), 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        last_grant = r;
        chk("busy_exec", int'(busy), 1);
        if (eager != 0) rsp_ready = 1'b1;
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("latency",  n, lat_exp);
        chk("rsp_data", int'(rsp_data), d_exp);
        chk("rsp_id",   int'(rsp_id), r);
        chk("rsp_dz",   int'(rsp_dz), (op == 3 && b == 0) ? 1 : 0);
        if (eager == 0) begin
            repeat (hold) begin
                tick();
                chk("hold_valid", int'(rsp_valid), 1);
                chk("hold_data",  int'(rsp_data), d_exp);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_drop",  int'(rsp_valid), 0);
        chk("busy_idle", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        int exp_g;
        int r, op, a, b;

        rst        = 1'b1;
        ena        = 1'b1;
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        req0_op    = '0; req0_a = '0; req0_b = '0;
        req1_op    = '0; req1_a = '0; req1_b = '0;

        // Reset state, including ready gated off while a request is pending
        tick();
        chk("rst_ready0",    int'(req0_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data",  int'(rsp_data), 0);
        chk("rst_rsp_id",    int'(rsp_id), 0);
        chk("rst_rsp_dz",    int'(rsp_dz), 0);
        chk("rst_busy",      int'(busy), 0);
        tick();
        rst        = 1'b0;
        req0_valid = 1'b0;
        tick();

        // Directed arithmetic
        run_txn(0, 0, 5, 6, 0, 0);
        run_txn(1, 1, 2, 5, 0, 0);
        run_txn(0, 2, 7, 7, 0, 0);
        run_txn(1, 3, 7, 2, 0, 0);
        run_txn(0, 3, 5, 0, 0, 0);

        // Enable low for two cycles mid-MUL
        drive_req(0, 2, 7, 7);
        #1;
        chk("ena_grant", int'(req0_ready), 1);
        tick();
        req0_valid = 1'b0;
        last_grant = 0;
        tick();
        ena = 1'b0;
        repeat (2) begin
            tick();
            chk("ena_hold_busy",  int'(busy), 1);
            chk("ena_hold_valid", int'(rsp_valid), 0);
        end
        ena = 1'b1;
        n = 3;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("ena_latency", n, OPW + 2);
        chk("ena_data",    int'(rsp_data), 49);
        ena       = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("ena_done_valid", int'(rsp_valid), 1);
        chk("ena_done_data",  int'(rsp_data), 49);
        ena = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("ena_done_drop", int'(rsp_valid), 0);

        // Reset pulse mid-MUL
        drive_req(1, 2, 7, 7);
        #1;
        tick();
        req1_valid = 1'b0;
        last_grant = 1;
        tick();
        chk("midrst_busy_before", int'(busy), 1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_ready0",    int'(req0_ready), 0);
        chk("midrst_ready1",    int'(req1_ready), 0);
        chk("midrst_rsp_valid", int'(rsp_valid), 0);
        chk("midrst_rsp_data",  int'(rsp_data), 0);
        chk("midrst_rsp_id",    int'(rsp_id), 0);
        chk("midrst_rsp_dz",    int'(rsp_dz), 0);
        chk("midrst_busy",      int'(busy), 0);
        tick();
        rst        = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        last_grant = 1;
        seen = 0;
        repeat (8) begin
            tick();
            if (rsp_valid || busy) seen = 1;
        end
        chk("midrst_no_rsp", seen, 0);

        // Contested round-robin with a 4-cycle response stall on the second grant
        drive_req(0, 0, 1, 2);
        drive_req(1, 0, 3, 4);
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_g = (last_grant == 0) ? 1 : 0;
            n = 0;
            while (!(req0_ready || req1_ready) && n < 40) begin
                tick();
                n++;
            end
            chk("rr_wait",   n, 0);
            chk("rr_grant1", int'(req1_ready), exp_g);
            chk("rr_grant0", int'(req0_ready), 1 - exp_g);
            tick();
            last_grant = exp_g;
            n = 0;
            while (!rsp_valid && n < 40) begin
                tick();
                n++;
            end
            chk("rr_latency", n, 1);
            chk("rr_id",      int'(rsp_id), exp_g);
            chk("rr_data",    int'(rsp_data), (exp_g == 1) ? 7 : 3);
            if (k == 1) begin
                repeat (4) begin
                    tick();
                    chk("stall_valid",  int'(rsp_valid), 1);
                    chk("stall_data",   int'(rsp_data), 7);
                    chk("stall_accept", int'(req0_ready || req1_ready), 0);
                end
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // Random single-requester traffic
        for (int i = 0; i < 30; i++) begin
            r  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 3));
            a  = int'($urandom_range(0, 7));
            b  = int'($urandom_range(0, 7));
            run_txn(r, op, a, b, int'($urandom_range(0, 2)),
                    ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
